// File: rtl/commit_tracker_pkg.sv
// Shared types and constants for the commit tracker: trap opcode, reset PC and state encoding.
package commit_tracker_pkg;

  typedef enum logic [1:0] {
    CT_RUN  = 2'b00,
    CT_HALT = 2'b01,
    CT_HANG = 2'b10
  } ct_state_e;

  localparam logic [6:0]  TRAP_OPCODE = 7'h6b;
  localparam logic [63:0] PC_START    = 64'h0000_0000_8000_0000;

  function automatic logic is_trap(input logic [6:0] opcode);
    return opcode == TRAP_OPCODE;
  endfunction

endpackage

// File: rtl/commit_tracker_popcnt.sv
// Combinational population count of the effective commit-valid vector.
module commit_tracker_popcnt #(
  parameter int N = 2,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  always_comb begin
    // NOTE: default every always_comb output before the loop so no latch is inferred.
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(bits[i]);
    end
  end

endmodule

// File: rtl/commit_tracker.sv
// Multi-lane retire monitor: registers commits, counts cycles/instructions, detects trap and hang.
// Optional COMMIT_PERF_EN builds the zero-commit idle_cnt counter; otherwise idle_cnt is tied 0.
module commit_tracker
  import commit_tracker_pkg::*;
#(
  parameter int              NLANE    = 2,
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] START_PC = XLEN'(PC_START),
  parameter int              TIMEOUT  = 5000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NLANE-1:0]      in_valid,
  input  logic [NLANE*XLEN-1:0] in_pc,
  input  logic [NLANE*32-1:0]   in_inst,
  input  logic [NLANE-1:0]      in_wen,
  input  logic [NLANE*5-1:0]    in_wdest,
  input  logic [NLANE*XLEN-1:0] in_wdata,
  input  logic [NLANE-1:0]      in_skip,
  input  logic [XLEN-1:0]       a0_value,
  output logic [NLANE-1:0]      out_valid,
  output logic [NLANE*XLEN-1:0] out_pc,
  output logic [NLANE*32-1:0]   out_inst,
  output logic [NLANE*XLEN-1:0] out_wdata,
  output logic [NLANE-1:0]      out_wen,
  output logic [NLANE*8-1:0]    out_wdest,
  output logic [NLANE-1:0]      out_skip,
  output logic [63:0]           cycle_cnt,
  output logic [63:0]           instr_cnt,
  output logic                  trap_valid,
  output logic [7:0]            trap_code,
  output logic [XLEN-1:0]       trap_pc,
  output logic                  hang,
  output logic [63:0]           idle_cnt
);

  localparam int CW = $clog2(NLANE + 1);

  ct_state_e        state;
  logic             first_q;
  logic [31:0]      wd_cnt;
  logic [NLANE-1:0] eff_valid;
  logic [CW-1:0]    n_commit;
  logic             trap_any;
  logic [XLEN-1:0]  trap_pc_sel;
  logic             run;
  logic             commit_any;
  logic             wd_expire;
  logic             unused_a0;

  assign run        = (state == CT_RUN);
  assign commit_any = |eff_valid;
  assign wd_expire  = (TIMEOUT != 0) && !commit_any && (wd_cnt == 32'(TIMEOUT - 1));
  assign trap_valid = (state == CT_HALT);
  assign hang       = (state == CT_HANG);
  assign unused_a0  = ^a0_value[XLEN-1:8];

  // Lanes are scanned oldest first; once a trap lane is seen, younger lanes are masked.
  always_comb begin
    eff_valid   = '0;
    trap_any    = 1'b0;
    trap_pc_sel = '0;
    for (int i = 0; i < NLANE; i++) begin
      if (!trap_any && in_valid[i]) begin
        eff_valid[i] = 1'b1;
        if (is_trap(in_inst[i*32 +: 7])) begin
          trap_any    = 1'b1;
          trap_pc_sel = in_pc[i*XLEN +: XLEN];
        end
      end
    end
  end

  commit_tracker_popcnt #(.N(NLANE), .W(CW)) u_popcnt (
    .bits  (eff_valid),
    .count (n_commit)
  );

  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block, and all state uses <=.
    if (reset) begin
      state     <= CT_RUN;
      first_q   <= 1'b1;
      wd_cnt    <= '0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      out_valid <= '0;
      trap_code <= '0;
      trap_pc   <= '0;
    end else begin
      out_valid <= '0;
      if (run) begin
        out_valid <= eff_valid;
        cycle_cnt <= cycle_cnt + 64'd1;
        instr_cnt <= instr_cnt + 64'(n_commit);
        if (commit_any) begin
          first_q <= 1'b0;
          wd_cnt  <= '0;
        end else begin
          wd_cnt  <= wd_cnt + 32'd1;
        end
        // A trap is itself a commit, so it always beats a watchdog expiry.
        if (trap_any) begin
          state     <= CT_HALT;
          trap_code <= a0_value[7:0];
          trap_pc   <= trap_pc_sel;
        end else if (wd_expire) begin
          state <= CT_HANG;
        end
      end
    end
  end

`ifdef COMMIT_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (run && !commit_any) begin
      idle_cnt <= idle_cnt + 64'd1;
    end
  end
`else
  assign idle_cnt = '0;
`endif

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] wdata_q;
    logic [31:0]     inst_q;
    logic [4:0]      wdest_q;
    logic            wen_q;
    logic            skip_q;

    // Lane payload is captured every RUN cycle regardless of valid and holds once stopped.
    always_ff @(posedge clock) begin
      if (reset) begin
        pc_q    <= '0;
        wdata_q <= '0;
        inst_q  <= '0;
        wdest_q <= '0;
        wen_q   <= 1'b0;
        skip_q  <= 1'b0;
      end else if (run) begin
        pc_q    <= in_pc[i*XLEN +: XLEN];
        wdata_q <= in_wdata[i*XLEN +: XLEN];
        inst_q  <= in_inst[i*32 +: 32];
        wdest_q <= in_wdest[i*5 +: 5];
        wen_q   <= in_wen[i] && (in_wdest[i*5 +: 5] != 5'd0);
        skip_q  <= in_skip[i] | (first_q && (in_pc[i*XLEN +: XLEN] == START_PC));
      end
    end

    assign out_pc[i*XLEN +: XLEN]    = pc_q;
    assign out_wdata[i*XLEN +: XLEN] = wdata_q;
    assign out_inst[i*32 +: 32]      = inst_q;
    assign out_wdest[i*8 +: 8]       = {3'b000, wdest_q};
    assign out_wen[i]                = wen_q;
    assign out_skip[i]               = skip_q;
  end

endmodule
